// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Fetch sequencer for the single-cycle RISC-V core. It owns the program
// counter, issues instruction-memory requests, and hands each fetched word to
// decode/execute under a valid/stall handshake. The next PC is either PC+4 or
// a redirect target. Fetching stops in a sticky HALT state when the next PC
// reaches END_ADDR, on a misaligned redirect, or on a fetch timeout.
//
// Parameters:
//   RESET_VEC  first fetch address after start
//   END_ADDR   first address that must not be fetched
//   TIMEOUT    FETCH cycles allowed without imem_ack before a fault (>= 1)
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             one-cycle start pulse (honoured in IDLE/HALT only)
//   imem_req          fetch request (high in FETCH)
//   imem_addr         fetch address, equal to pc
//   imem_ack          memory accepted request, imem_rdata valid this cycle
//   imem_rdata        instruction word from memory
//   inst_valid        inst/inst_pc hold a pending instruction (high in EXEC)
//   inst, inst_pc     captured instruction and its address
//   stall             consumer not ready, instruction held
//   redirect_valid    use redirect_pc as next PC (consume cycle only)
//   redirect_pc       branch/jump target
//   halted            in HALT
//   err               0 none, 1 misaligned redirect, 2 fetch timeout
//   retired           consumed-instruction count, wraps mod 2^32
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] END_ADDR  = 32'h0000_0024,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic [1:0]  err,
    output logic [31:0] retired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t          state;
    logic [31:0]     pc;
    logic [CW-1:0]   wait_cnt;
    logic [31:0]     next_pc;
    logic            redirect_bad;

    // Only meaningful in the consume cycle; the FSM ignores it elsewhere.
    assign next_pc      = redirect_valid ? redirect_pc : pc + 32'd4;
    assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // Outputs decode straight from registers, so no input reaches an output
    // combinationally.
    assign imem_req   = (state == FETCH);
    assign inst_valid = (state == EXEC);
    assign halted     = (state == HALT);
    assign imem_addr  = pc;

    // NOTE: every register here is updated with non-blocking assignments so
    // all of them see the same pre-edge values; the async reset sits in the
    // sensitivity list so it acts without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_VEC;
            wait_cnt <= '0;
            inst     <= '0;
            inst_pc  <= '0;
            err      <= ERR_NONE;
            retired  <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state    <= FETCH;
                        pc       <= RESET_VEC;
                        wait_cnt <= '0;
                        err      <= ERR_NONE;
                        retired  <= '0;
                    end
                end

                FETCH: begin
                    if (imem_ack) begin
                        inst     <= imem_rdata;
                        inst_pc  <= pc;
                        wait_cnt <= '0;
                        state    <= EXEC;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        // This was the TIMEOUT-th FETCH cycle without an ack.
                        wait_cnt <= '0;
                        err      <= ERR_TIMEOUT;
                        state    <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end

                EXEC: begin
                    if (!stall) begin
                        retired <= retired + 32'd1;
                        if (redirect_bad) begin
                            // pc keeps the faulting instruction's address.
                            err   <= ERR_MISALIGN;
                            state <= HALT;
                        end else if (next_pc >= END_ADDR) begin
                            pc    <= next_pc;
                            err   <= ERR_NONE;
                            state <= HALT;
                        end else begin
                            pc    <= next_pc;
                            state <= FETCH;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//
// Directed self-checking bench for pc_fetch_ctrl (TIMEOUT overridden to 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic [1:0]  err;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int c0;

    pc_fetch_ctrl #(
        .RESET_VEC (32'h0000_0000),
        .END_ADDR  (32'h0000_0024),
        .TIMEOUT   (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .err            (err),
        .retired        (retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},     32'(imem_req),   32'd0);
        check({tag, "_addr"},    imem_addr,       32'h0);
        check({tag, "_valid"},   32'(inst_valid), 32'd0);
        check({tag, "_inst"},    inst,            32'h0);
        check({tag, "_inst_pc"}, inst_pc,         32'h0);
        check({tag, "_halted"},  32'(halted),     32'd0);
        check({tag, "_err"},     32'(err),        32'd0);
        check({tag, "_retired"}, retired,         32'd0);
    endtask

    // Entered in a FETCH cycle; returns in the first EXEC cycle.
    task automatic do_fetch(input logic [31:0] addr, input int waits, input logic [31:0] word);
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_addr", imem_addr, addr);
        for (int w = 0; w < waits; w++) begin
            step();
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_addr", imem_addr, addr);
            check("wait_valid", 32'(inst_valid), 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("exec_valid", 32'(inst_valid), 32'd1);
        check("exec_inst", inst, word);
        check("exec_inst_pc", inst_pc, addr);
    endtask

    // Entered in the first EXEC cycle; stalls, then consumes.
    task automatic do_exec(input int stalls, input logic [31:0] addr, input logic [31:0] word,
                           input logic redir, input logic [31:0] rpc);
        for (int s = 0; s < stalls; s++) begin
            stall          = 1'b1;
            redirect_valid = redir;
            redirect_pc    = rpc;
            step();
            check("stall_valid", 32'(inst_valid), 32'd1);
            check("stall_inst", inst, word);
            check("stall_inst_pc", inst_pc, addr);
        end
        stall          = 1'b0;
        redirect_valid = redir;
        redirect_pc    = rpc;
        step();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    task automatic straight_run(input string tag);
        c0 = cyc;
        for (int i = 0; i < 9; i++) begin
            do_fetch(32'(i * 4), 0, 32'h0000_0013 + 32'(i << 7));
            do_exec(0, 32'(i * 4), 32'h0000_0013 + 32'(i << 7), 1'b0, 32'h0);
        end
        check({tag, "_halted"}, 32'(halted), 32'd1);
        check({tag, "_retired"}, retired, 32'd9);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_pc"}, imem_addr, 32'h24);
        check({tag, "_cycles"}, 32'(cyc - c0), 32'd18);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        #3;
        check_reset_values("rst");
        step();
        rst_n = 1'b1;
        step();
        check_reset_values("idle");

        // Straight-line run, zero-wait memory
        pulse_start();
        straight_run("run1");
        step();
        check("halt_sticky", 32'(halted), 32'd1);
        check("halt_no_req", 32'(imem_req), 32'd0);

        // Wait states on 0x08, stall on 0x0C, redirect held off by stall on 0x10
        pulse_start();
        check("restart_retired", retired, 32'd0);
        c0 = cyc;
        do_fetch(32'h00, 0, 32'hA000_0000);
        do_exec(0, 32'h00, 32'hA000_0000, 1'b0, 32'h0);
        do_fetch(32'h04, 0, 32'hA000_0004);
        do_exec(0, 32'h04, 32'hA000_0004, 1'b0, 32'h0);
        do_fetch(32'h08, 3, 32'hA000_0008);
        do_exec(0, 32'h08, 32'hA000_0008, 1'b0, 32'h0);
        do_fetch(32'h0C, 0, 32'hA000_000C);
        do_exec(2, 32'h0C, 32'hA000_000C, 1'b0, 32'h0);
        do_fetch(32'h10, 0, 32'hA000_0010);
        do_exec(1, 32'h10, 32'hA000_0010, 1'b1, 32'h04);
        // 2 + 2 + (1+3+1) + (1+3) + (1+2) cycles
        check("ws_cycles", 32'(cyc - c0), 32'd16);
        check("ws_retired", retired, 32'd5);
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", imem_addr, 32'h04);

        // Misaligned redirect faults and keeps pc
        do_fetch(32'h04, 0, 32'hB000_0004);
        do_exec(0, 32'h04, 32'hB000_0004, 1'b1, 32'h0A);
        check("mis_halted", 32'(halted), 32'd1);
        check("mis_err", 32'(err), 32'd1);
        check("mis_pc", imem_addr, 32'h04);
        check("mis_valid", 32'(inst_valid), 32'd0);

        // Fetch timeout after 4 FETCH cycles, late ack ignored
        pulse_start();
        check("to_err_clr", 32'(err), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("to_still_fetch", 32'(imem_req), 32'd1);
            check("to_addr", imem_addr, 32'h00);
        end
        step();
        check("to_halted", 32'(halted), 32'd1);
        check("to_err", 32'(err), 32'd2);
        check("to_req", 32'(imem_req), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        imem_ack   = 1'b0;
        check("late_ack_halted", 32'(halted), 32'd1);
        check("late_ack_valid", 32'(inst_valid), 32'd0);
        check("late_ack_err", 32'(err), 32'd2);
        pulse_start();
        check("to_restart_err", 32'(err), 32'd0);
        check("to_restart_req", 32'(imem_req), 32'd1);
        check("to_restart_addr", imem_addr, 32'h00);
        check("to_restart_halted", 32'(halted), 32'd0);

        // Asynchronous reset during EXEC with retired=5
        for (int i = 0; i < 5; i++) begin
            do_fetch(32'(i * 4), 0, 32'hC000_0000 + 32'(i));
            do_exec(0, 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b0, 32'h0);
        end
        do_fetch(32'h14, 0, 32'hC000_0005);
        stall = 1'b1;
        check("pre_rst_retired", retired, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        start = 1'b1;
        step();
        check("rst_start_ignored", 32'(imem_req), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        step();
        check_reset_values("post_rst");

        // Clean run after reset
        pulse_start();
        straight_run("run2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
